// File: rtl/truth_table_probe.sv
// Sweeps every input combination of a small gate, holds each for SETTLE+1 cycles,
// samples the gate output at the end of each window and assembles the truth table.
module truth_table_probe #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN-1:0]      probe_in,
  input  logic                 probe_out,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 table_valid
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX  = '1;

  state_t              state_q;
  logic [N_IN-1:0]     idx_q;
  logic [3:0]          cnt_q;
  logic [2**N_IN-1:0]  table_q;
  logic                valid_q;
  logic                done_q;
  logic                busy_q;
  logic [N_IN-1:0]     probe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      probe_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            table_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= SETTLE_LD;
            busy_q  <= 1'b1;
            probe_q <= '0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // abort outranks the final sample, so a late cancel never yields done
          if (abort) begin
            busy_q  <= 1'b0;
            probe_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            table_q[idx_q] <= probe_out;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              probe_q <= '0;
              idx_q   <= '0;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              probe_q <= idx_q + 1'b1;
              cnt_q   <= SETTLE_LD;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign probe_in    = probe_q;
  assign table_out   = table_q;
  assign table_valid = valid_q;

endmodule
